// File: rtl/bias_stream_loader_if.sv
// Bias stream bundle: ap_fifo read side (dout/empty_n/read) plus the ROM-style bias read port.
// master = producer/consumer environment, slave = bias_stream_loader.
interface bias_stream_loader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] input_V_dout;
  logic                  input_V_empty_n;
  logic                  input_V_read;
  logic [ADDR_WIDTH-1:0] bias_V_address0;
  logic                  bias_V_ce0;
  logic [DATA_WIDTH-1:0] bias_V_q0;

  modport master (
    output input_V_dout, input_V_empty_n, bias_V_address0, bias_V_ce0,
    input  input_V_read, bias_V_q0
  );

  modport slave (
    input  input_V_dout, input_V_empty_n, bias_V_address0, bias_V_ce0,
    output input_V_read, bias_V_q0
  );
endinterface

// File: rtl/bias_stream_loader.sv
// Drains MEM_SIZE bias words from an ap_fifo stream into a table served via a 1-cycle ROM port.
// Optional macro BIAS_STREAM_RELOAD_EN: a pop while READY starts loading a fresh table.
module bias_stream_loader #(
  parameter int unsigned MEM_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  bias_stream_loader_if.slave    bus,
  output logic                   loaded
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_SIZE - 1);
  localparam logic [CNT_W-1:0] MEM_DEPTH = CNT_W'(MEM_SIZE);

  typedef enum logic {S_LOAD, S_READY} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_wr_cnt, w_wr_cnt_nxt;
  logic                  r_loaded, w_loaded_nxt;
  logic                  w_read;
  logic [DATA_WIDTH-1:0] r_q0;
  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

  // State, write counter and loaded flag
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state  <= S_LOAD;
      r_wr_cnt <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_loaded <= w_loaded_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_loaded_nxt = r_loaded;
    w_read       = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_read = bus.input_V_empty_n;
        if (w_read) begin
          if (r_wr_cnt == LAST_IDX) begin
            w_state_nxt  = S_READY;
            w_wr_cnt_nxt = '0;
            w_loaded_nxt = 1'b1;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
          end
        end
      end
      S_READY: begin
`ifdef BIAS_STREAM_RELOAD_EN
        // Pop lands in mem[0] (wr_cnt is 0 here); a one-word table simply stays READY
        w_read = bus.input_V_empty_n;
        if (w_read && (MEM_SIZE > 1)) begin
          w_state_nxt  = S_LOAD;
          w_wr_cnt_nxt = CNT_W'(1);
          w_loaded_nxt = 1'b0;
        end
`else
        w_read = 1'b0;
`endif
      end
    endcase
  end

  // Table storage, intentionally not reset
  always_ff @(posedge ap_clk) begin
    if (w_read) begin
      r_mem[r_wr_cnt[ADDR_WIDTH-1:0]] <= bus.input_V_dout;
    end
  end

  // ROM-style read port; out-of-range addresses return zero rather than wrapping
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_q0 <= '0;
    end else if (bus.bias_V_ce0 && r_loaded) begin
      if ({1'b0, bus.bias_V_address0} < MEM_DEPTH) begin
        r_q0 <= r_mem[bus.bias_V_address0];
      end else begin
        r_q0 <= '0;
      end
    end
  end

  assign bus.input_V_read = w_read;
  assign bus.bias_V_q0    = r_q0;
  assign loaded           = r_loaded;

endmodule

// File: tb/tb_bias_stream_loader.sv
// Directed bench for bias_stream_loader: 16-entry and 12-entry instances, scoreboard-checked reads.
module tb_bias_stream_loader;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  logic loaded16;
  logic loaded12;

  bias_stream_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b16 ();
  bias_stream_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b12 ();

  bias_stream_loader #(.MEM_SIZE(16), .DATA_WIDTH(DW)) dut16 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (b16.slave),
    .loaded   (loaded16)
  );

  bias_stream_loader #(.MEM_SIZE(12), .DATA_WIDTH(DW)) dut12 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (b12.slave),
    .loaded   (loaded12)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Push n words base, base+1, ... into dut16; ncyc returns the cycles taken
  task automatic stream16(input logic [15:0] base, input int n, input bit toggle,
                          input bit hold_zero, output int ncyc);
    int idx;
    bit ph;
    bit pop;
    idx  = 0;
    ph   = 1'b1;
    ncyc = 0;
    while (idx < n && ncyc < 200) begin
      b16.input_V_empty_n = toggle ? ph : 1'b1;
      b16.input_V_dout    = base + 16'(idx);
      #1;
      check("read_eq_empty_n", 32'(b16.input_V_read), 32'(b16.input_V_empty_n));
      check("loaded_low_in_load", 32'(loaded16), 32'(0));
      if (hold_zero) check("q0_hold_in_load", 32'(b16.bias_V_q0), 32'(0));
      pop = b16.input_V_empty_n;
      tick();
      if (pop) idx++;
      ncyc++;
      ph = ~ph;
    end
    b16.input_V_empty_n = 1'b0;
  endtask

  // Read addresses 0..15 back-to-back, expecting base+addr one cycle later
  task automatic sweep16(input logic [15:0] base);
    for (int a = 0; a < 16; a++) begin
      b16.bias_V_ce0      = 1'b1;
      b16.bias_V_address0 = AW'(a);
      sb.push_back(base + 16'(a));
      tick();
      check("q0_sweep", 32'(b16.bias_V_q0), 32'(sb.pop_front()));
    end
    b16.bias_V_ce0 = 1'b0;
  endtask

  task automatic read12(input logic [AW-1:0] addr, input logic [15:0] exp);
    b12.bias_V_ce0      = 1'b1;
    b12.bias_V_address0 = addr;
    sb.push_back(exp);
    tick();
    check("q0_m12", 32'(b12.bias_V_q0), 32'(sb.pop_front()));
    b12.bias_V_ce0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc;
    ap_rst_n = 1'b0;
    b16.input_V_dout = '0; b16.input_V_empty_n = 1'b0;
    b16.bias_V_address0 = '0; b16.bias_V_ce0 = 1'b0;
    b12.input_V_dout = '0; b12.input_V_empty_n = 1'b0;
    b12.bias_V_address0 = '0; b12.bias_V_ce0 = 1'b0;

    // Reset state
    #12;
    check("rst_loaded", 32'(loaded16), 32'(0));
    check("rst_q0", 32'(b16.bias_V_q0), 32'(0));
    check("rst_read", 32'(b16.input_V_read), 32'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();

    // Continuous stream of 16 words
    stream16(16'h0001, 16, 1'b0, 1'b0, nc);
    check("cont_cycles", 32'(nc), 32'(16));
    check("cont_loaded", 32'(loaded16), 32'(1));
    sweep16(16'h0001);
    b16.bias_V_address0 = AW'(5);
    tick();
    check("q0_hold_ce0_low", 32'(b16.bias_V_q0), 32'h0010);

    // Extra 17th word after load
    b16.input_V_empty_n = 1'b1;
    b16.input_V_dout    = 16'h0011;
`ifdef BIAS_STREAM_RELOAD_EN
    #1;
    check("extra_read", 32'(b16.input_V_read), 32'(1));
    tick();
    check("extra_loaded_drop", 32'(loaded16), 32'(0));
    stream16(16'h0012, 15, 1'b0, 1'b0, nc);
    check("reload_cycles", 32'(nc), 32'(15));
    check("reload_loaded", 32'(loaded16), 32'(1));
    sweep16(16'h0011);
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      check("extra_read_blocked", 32'(b16.input_V_read), 32'(0));
      tick();
      check("extra_loaded_kept", 32'(loaded16), 32'(1));
    end
    b16.input_V_empty_n = 1'b0;
    sweep16(16'h0001);
`endif

    // Asynchronous reset mid-cycle clears loaded and q0 at once
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_loaded", 32'(loaded16), 32'(0));
    check("async_rst_q0", 32'(b16.bias_V_q0), 32'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();

    // Toggling empty_n with reads of addr 3 held during load
    b16.bias_V_ce0      = 1'b1;
    b16.bias_V_address0 = AW'(3);
    stream16(16'h0001, 16, 1'b1, 1'b1, nc);
    check("toggle_cycles", 32'(nc), 32'(31));
    check("toggle_loaded", 32'(loaded16), 32'(1));
    check("q0_hold_final_pop", 32'(b16.bias_V_q0), 32'(0));
    tick();
    check("q0_first_read", 32'(b16.bias_V_q0), 32'h0004);
    b16.bias_V_ce0 = 1'b0;
    sweep16(16'h0001);

    // Reset after 7 pops, then a full new table
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("rst2_loaded", 32'(loaded16), 32'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();
    stream16(16'h5500, 7, 1'b0, 1'b0, nc);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("midload_rst_loaded", 32'(loaded16), 32'(0));
    check("midload_rst_read", 32'(b16.input_V_read), 32'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();
    stream16(16'hA000, 16, 1'b0, 1'b0, nc);
    check("reload_a_cycles", 32'(nc), 32'(16));
    check("reload_a_loaded", 32'(loaded16), 32'(1));
    sweep16(16'hA000);

    // Non-power-of-two table: 12 words, out-of-range reads return zero
    for (int k = 0; k < 12; k++) begin
      b12.input_V_empty_n = 1'b1;
      b12.input_V_dout    = 16'h0C00 + 16'(k);
      #1;
      check("m12_read", 32'(b12.input_V_read), 32'(1));
      check("m12_loaded_low", 32'(loaded12), 32'(0));
      tick();
    end
    b12.input_V_empty_n = 1'b0;
    check("m12_loaded", 32'(loaded12), 32'(1));
    read12(AW'(11), 16'h0C0B);
    read12(AW'(13), 16'h0000);
    read12(AW'(0),  16'h0C00);
    read12(AW'(12), 16'h0000);
    read12(AW'(5),  16'h0C05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
